hc_sr04_echo_emulator: RTL and testbench
========================================

Name: hc_sr04_echo_emulator

Overview:
- Synthesizable model of the HC-SR04 sensor side of the ultrasonic protocol. It is the responder to our trigger/echo measurement controller.
- It accepts a trigger pulse and waits out the emulated 40 kHz burst time. It then drives an echo pulse whose width encodes a programmed distance.
- Used on-board as a stand-in sensor for loopback bring-up, and in simulation as the sensor for controller and distance-calculator benches.

Parameters:
- CLK_PER_US, 100: clk cycles per microsecond (100 MHz clk).
- MIN_TRIG_US, 10: minimum accepted trigger high width, in us.
- BURST_US, 200: delay from accepted trigger fall to echo rise, in us.
- US_PER_CM, 58: echo width per cm, in us.
- MIN_CM, 2: smallest in-range distance.
- MAX_CM, 400: largest in-range distance.
- TIMEOUT_US, 38000: echo width for an out-of-range distance, in us.
- HOLDOFF_US, 1000: dead time after echo fall during which triggers are ignored, in us.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- trig  input  1  trigger from controller; synchronous to clk.
- dist_cm  input  9  emulated distance in cm, unsigned.
- echo  output  1  echo pulse, registered.
- busy  output  1  high whenever state is not IDLE.
- trig_err  output  1  one-cycle pulse when a trigger is rejected as too short.
- meas_done  output  1  one-cycle pulse in the cycle echo falls.

Behaviour:
- Reset (rst=0): state IDLE; echo, busy, trig_err, meas_done all 0; all counters 0. Takes effect immediately, including mid-echo (echo drops asynchronously). Operation resumes at the first clk edge after rst=1.
- Edge detection: trig is registered once (trig_q). A rising edge is trig=1 and trig_q=0 at an edge; a falling edge is trig=0 and trig_q=1.
- Timing counters: a us prescaler (0..CLK_PER_US-1) and a us counter (16 bits) are cleared on every state entry. All durations are therefore exact clk multiples, not tick-aligned.
- States: IDLE, TRIG, BURST, ECHO, HOLDOFF.
- IDLE:
  - A rising edge of trig moves to TRIG; the width counter starts at 1.
  - trig already high on entry to IDLE is not a rising edge. A new 0->1 transition is required.
- TRIG:
  - Count edges at which trig=1; the counter saturates at MIN_TRIG_US*CLK_PER_US.
  - On the falling edge (edge F), if count >= MIN_TRIG_US*CLK_PER_US: latch dist_cm, compute the width, go to BURST.
  - Otherwise pulse trig_err at edge F+1 and return to IDLE.
- Width computation:
  - W_us = dist*US_PER_CM if MIN_CM <= dist <= MAX_CM, else TIMEOUT_US.
  - 9x6-bit product is 15 bits; the register is 16 bits.
  - dist changes after edge F have no effect on the current measurement.
- BURST: echo rises at edge F + BURST_US*CLK_PER_US; go to ECHO.
- ECHO:
  - echo stays high for exactly W_us*CLK_PER_US clk cycles.
  - At the falling edge of echo, meas_done=1 for that one cycle; go to HOLDOFF.
- HOLDOFF: lasts HOLDOFF_US*CLK_PER_US cycles, then IDLE.
- Trig activity in BURST, ECHO or HOLDOFF is ignored entirely. trig_err is not raised and the trig_q history does not create a deferred edge.
- busy goes to 1 on the edge entering TRIG and returns to 0 on the edge entering IDLE.
- Only one measurement is in flight at a time. There is no queueing.

Test Plan:
- Accepted trigger, nominal distance:
  - Stimulus: dist_cm=100, trig high for 1000 cycles.
  - Required: echo rises 20000 cycles after F and is high for 580000 cycles.
  - Required: meas_done pulses once; busy drops 100000 cycles after echo falls; trig_err stays 0.
- Short trigger:
  - Stimulus: trig high for 999 cycles.
  - Required: echo never rises; trig_err is high for exactly 1 cycle at F+1; busy returns to 0 the same edge.
- Out-of-range and minimum distance:
  - Stimulus: dist_cm=0, then 401, then 511.
  - Required: echo width 3800000 cycles each time.
  - Stimulus: dist_cm=2. Required: echo width 11600 cycles.
- Retrigger rejection:
  - Stimulus: 1000-cycle trig pulses during BURST, ECHO and HOLDOFF. Required: no timing change, no trig_err.
  - Stimulus: trig raised in HOLDOFF and held past IDLE entry. Required: no new measurement until trig goes 0 then 1.
- Latching: change dist_cm 100->300 one cycle after F -> echo width remains 580000 cycles.
- Reset mid-echo:
  - Stimulus: assert rst=0 halfway through echo.
  - Required: echo=0 and busy=0 immediately.
  - Stimulus: release rst, then apply a valid trigger with dist_cm=50. Required: echo width 290000 cycles.

Source files
------------

// File: rtl/hc_sr04_echo_emulator_if.sv
// rtl/hc_sr04_echo_emulator_if.sv - trigger/echo link between measurement controller and sensor
interface hc_sr04_echo_emulator_if;
  logic       trig;
  logic [8:0] dist_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;
  logic       meas_done;

  modport master (
    output trig,
    output dist_cm,
    input  echo,
    input  busy,
    input  trig_err,
    input  meas_done
  );

  modport slave (
    input  trig,
    input  dist_cm,
    output echo,
    output busy,
    output trig_err,
    output meas_done
  );
endinterface

// File: rtl/hc_sr04_echo_emulator.sv
// rtl/hc_sr04_echo_emulator.sv - HC-SR04 sensor side: accepts a trigger, answers with a distance-coded echo
module hc_sr04_echo_emulator #(
  parameter int CLK_PER_US  = 100,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = 58,
  parameter int MIN_CM      = 2,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  hc_sr04_echo_emulator_if.slave  sio
);

  localparam int PW           = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int MIN_TRIG_CYC = MIN_TRIG_US * CLK_PER_US;
  localparam int WCW          = $clog2(MIN_TRIG_CYC + 1);

  localparam logic [PW-1:0]  PRE_MAX     = PW'(CLK_PER_US - 1);
  localparam logic [WCW-1:0] WCNT_MAX    = WCW'(MIN_TRIG_CYC);
  localparam logic [15:0]    BURST_LAST  = 16'(BURST_US - 1);
  localparam logic [15:0]    HOLD_LAST   = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]    TIMEOUT_W   = 16'(TIMEOUT_US);
  localparam logic [15:0]    US_PER_CM_W = 16'(US_PER_CM);
  localparam logic [8:0]     MIN_CM_W    = 9'(MIN_CM);
  localparam logic [8:0]     MAX_CM_W    = 9'(MAX_CM);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  state_t         state_q, state_d;
  logic           trig_q, trig_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           rej_q, rej_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [15:0]    us_q, us_d;
  logic [15:0]    w_q, w_d;
  logic           echo_q, echo_d;
  logic           busy_q, busy_d;
  logic           trig_err_q, trig_err_d;
  logic           meas_done_q, meas_done_d;

  logic           trig_rise;
  logic           trig_fall;
  logic           tick_last;
  logic           in_range;
  logic [15:0]    w_calc;

  assign trig_rise = sio.trig & ~trig_q;
  assign trig_fall = ~sio.trig & trig_q;
  assign tick_last = (pre_q == PRE_MAX);
  assign in_range  = (sio.dist_cm >= MIN_CM_W) && (sio.dist_cm <= MAX_CM_W);
  assign w_calc    = in_range ? ({7'd0, sio.dist_cm} * US_PER_CM_W) : TIMEOUT_W;

  always_comb begin
    state_d     = state_q;
    trig_d      = sio.trig;
    wcnt_d      = wcnt_q;
    rej_d       = 1'b0;
    w_d         = w_q;
    trig_err_d  = 1'b0;
    meas_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_rise) begin
          state_d = ST_TRIG;
          wcnt_d  = WCW'(1);
        end
      end
      ST_TRIG: begin
        // A short pulse lingers here one extra cycle so trig_err and the return to IDLE land together.
        if (rej_q) begin
          state_d    = ST_IDLE;
          trig_err_d = 1'b1;
        end else if (trig_fall) begin
          if (wcnt_q >= WCNT_MAX) begin
            w_d     = w_calc;
            state_d = ST_BURST;
          end else begin
            rej_d = 1'b1;
          end
        end else if (sio.trig && (wcnt_q != WCNT_MAX)) begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_BURST: begin
        if (tick_last && (us_q == BURST_LAST)) begin
          state_d = ST_ECHO;
        end
      end
      ST_ECHO: begin
        if (tick_last && (us_q == (w_q - 16'd1))) begin
          state_d     = ST_HOLDOFF;
          meas_done_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (tick_last && (us_q == HOLD_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timebase restarts on every state entry so each phase is an exact cycle count.
    if ((state_d != state_q) || (state_q inside {ST_IDLE, ST_TRIG})) begin
      pre_d = '0;
      us_d  = '0;
    end else if (tick_last) begin
      pre_d = '0;
      us_d  = us_q + 16'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      us_d  = us_q;
    end

    echo_d = (state_d == ST_ECHO);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      trig_q      <= 1'b0;
      wcnt_q      <= '0;
      rej_q       <= 1'b0;
      pre_q       <= '0;
      us_q        <= '0;
      w_q         <= '0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      meas_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      wcnt_q      <= wcnt_d;
      rej_q       <= rej_d;
      pre_q       <= pre_d;
      us_q        <= us_d;
      w_q         <= w_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      trig_err_q  <= trig_err_d;
      meas_done_q <= meas_done_d;
    end
  end

  assign sio.echo      = echo_q;
  assign sio.busy      = busy_q;
  assign sio.trig_err  = trig_err_q;
  assign sio.meas_done = meas_done_q;

endmodule

// File: tb/tb_hc_sr04_echo_emulator.sv
// tb/tb_hc_sr04_echo_emulator.sv - directed bench for hc_sr04_echo_emulator with scaled-down timing
module tb_hc_sr04_echo_emulator;

  // 4 clk/us, 10 us min trig (40 cyc), 20 us burst (80 cyc), 3 us/cm, 1500 us timeout (6000 cyc), 25 us holdoff (100 cyc)
  localparam int MT      = 40;
  localparam int BURST_C = 80;
  localparam int HOLD_C  = 100;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;

  int   rise_cyc, fall_cyc, bfall_cyc, te_cyc, md_cyc;
  int   rise_cnt, md_cnt, te_cnt;
  logic echo_p, busy_p;

  hc_sr04_echo_emulator_if io();

  hc_sr04_echo_emulator #(
    .CLK_PER_US (4),
    .MIN_TRIG_US(10),
    .BURST_US   (20),
    .US_PER_CM  (3),
    .MIN_CM     (2),
    .MAX_CM     (400),
    .TIMEOUT_US (1500),
    .HOLDOFF_US (25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sio(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rise_cyc = 0; fall_cyc = 0; bfall_cyc = 0; te_cyc = 0; md_cyc = 0;
    rise_cnt = 0; md_cnt = 0; te_cnt = 0;
    echo_p = 1'b0; busy_p = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (io.echo && !echo_p) begin rise_cyc = cyc; rise_cnt++; end
    if (!io.echo && echo_p) fall_cyc = cyc;
    if (!io.busy && busy_p) bfall_cyc = cyc;
    if (io.meas_done) begin md_cnt++; md_cyc = cyc; end
    if (io.trig_err) begin te_cnt++; te_cyc = cyc; end
    echo_p = io.echo;
    busy_p = io.busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trigger high for n clk edges; f returns the edge index that sees the fall.
  task automatic pulse(input int n, output int f);
    @(negedge clk);
    io.trig = 1'b1;
    repeat (n) @(negedge clk);
    io.trig = 1'b0;
    f = cyc + 1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((io.busy !== 1'b0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, {31'd0, io.busy}, 32'd0);
  endtask

  task automatic wait_echo(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while ((io.echo !== lvl) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_echo_timeout"}, {31'd0, io.echo}, {31'd0, lvl});
  endtask

  task automatic measure(input int d, input int tlen, input int w_exp, input string tag);
    int f, r0, m0, t0;
    io.dist_cm = 9'(d);
    r0 = rise_cnt; m0 = md_cnt; t0 = te_cnt;
    pulse(tlen, f);
    wait_idle(20000, tag);
    chk({tag, "_rise_dly"}, rise_cyc - f, BURST_C);
    chk({tag, "_width"}, fall_cyc - rise_cyc, w_exp);
    chk({tag, "_holdoff"}, bfall_cyc - fall_cyc, HOLD_C);
    chk({tag, "_rises"}, rise_cnt - r0, 1);
    chk({tag, "_md_cnt"}, md_cnt - m0, 1);
    chk({tag, "_md_cyc"}, md_cyc, fall_cyc);
    chk({tag, "_trig_err"}, te_cnt - t0, 0);
  endtask

  initial begin
    int f, fx, r1, t1;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    io.trig = 1'b0;
    io.dist_cm = 9'd0;

    repeat (3) @(negedge clk);
    chk("rst_echo", {31'd0, io.echo}, 32'd0);
    chk("rst_busy", {31'd0, io.busy}, 32'd0);
    chk("rst_trig_err", {31'd0, io.trig_err}, 32'd0);
    chk("rst_meas_done", {31'd0, io.meas_done}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // nominal, trigger exactly at the minimum width
    measure(100, MT, 1200, "nominal");

    // short trigger: one edge under the minimum
    t1 = te_cnt; r1 = rise_cnt;
    pulse(MT - 1, f);
    repeat (5) @(negedge clk);
    chk("short_te_cyc", te_cyc, f + 1);
    chk("short_busy_fall", bfall_cyc, f + 1);
    chk("short_te_cnt", te_cnt - t1, 1);
    chk("short_te_now", {31'd0, io.trig_err}, 32'd0);
    repeat (300) @(negedge clk);
    chk("short_no_echo", rise_cnt - r1, 0);

    // distance table: out-of-range, limits, long (saturating) trigger
    measure(0,   MT,  6000, "d0");
    measure(401, MT,  6000, "d401");
    measure(511, MT,  6000, "d511");
    measure(1,   MT,  6000, "d1");
    measure(2,   200, 24,   "d2");
    measure(400, MT,  4800, "d400");

    // retrigger during BURST, ECHO and HOLDOFF
    io.dist_cm = 9'd100;
    r1 = rise_cnt; t1 = te_cnt;
    pulse(MT, f);
    repeat (10) @(negedge clk);
    pulse(MT, fx);
    wait_echo(1'b1, 200, "rt_rise");
    pulse(MT, fx);
    wait_echo(1'b0, 2000, "rt_fall");
    pulse(MT, fx);
    wait_idle(2000, "rt");
    chk("rt_rise_dly", rise_cyc - f, BURST_C);
    chk("rt_width", fall_cyc - rise_cyc, 1200);
    chk("rt_holdoff", bfall_cyc - fall_cyc, HOLD_C);
    chk("rt_rises", rise_cnt - r1, 1);
    chk("rt_trig_err", te_cnt - t1, 0);

    // trig raised in HOLDOFF and held into IDLE must not start a measurement
    pulse(MT, f);
    wait_echo(1'b0, 2000, "hold");
    repeat (10) @(negedge clk);
    io.trig = 1'b1;
    wait_idle(2000, "hold");
    r1 = rise_cnt;
    repeat (50) @(negedge clk);
    chk("hold_busy", {31'd0, io.busy}, 32'd0);
    chk("hold_no_rise", rise_cnt - r1, 0);
    io.trig = 1'b0;
    measure(100, MT, 1200, "rearm");

    // distance latched at the trigger fall
    io.dist_cm = 9'd100;
    pulse(MT, f);
    @(negedge clk);
    io.dist_cm = 9'd300;
    wait_idle(20000, "latch");
    chk("latch_width", fall_cyc - rise_cyc, 1200);

    // reset mid-echo
    io.dist_cm = 9'd100;
    pulse(MT, f);
    wait_echo(1'b1, 200, "mid_rst");
    repeat (600) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_echo", {31'd0, io.echo}, 32'd0);
    chk("mid_rst_busy", {31'd0, io.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    measure(50, MT, 600, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
